// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Legal memory read latency range; the latency counter is sized for MEM_LAT_MAX-1.
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int LAT_W       = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } owner_e;

    // One accepted transaction, captured at the end of the accept cycle.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wr;
        owner_e      owner;
    } req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side fetch/data handshakes plus the unified memory port.
interface mem_arbiter_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter view: serves the requesters, drives the memory port.
    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Environment view: requesters plus the memory that answers them.
    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_grant.sv
// Data-first grant with a starvation counter that forces a fetch through.
module mem_arb_grant #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic accept_i,
    input  logic inst_req_i,
    input  logic data_req_i,
    output logic grant_inst_o,
    output logic grant_data_o
);

    // Two spare bits keep the saturating compare clear of wrap-around.
    localparam int CNT_W = $clog2(STARVE_MAX + 1) + 2;

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved;

    // Combinational priority: data wins unless the pending fetch has waited long enough.
    always_comb begin
        starved      = inst_req_i && (starve_cnt_q == CNT_W'(STARVE_MAX));
        grant_data_o = accept_i && data_req_i && !starved;
        grant_inst_o = accept_i && inst_req_i && (!data_req_i || starved);
    end

    // Count data grants that bypass a waiting fetch; any fetch grant or idle fetch clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!inst_req_i || grant_inst_o) begin
            starve_cnt_d = '0;
        end else if (grant_data_o && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data access.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.slave  bus,
    output logic          busy
);

    // Out-of-range latencies are clamped so the counter width always suffices.
    localparam int LAT_EFF = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                             (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    req_t               req_q, req_d;
    logic [31:0]        inst_rdata_q, inst_rdata_d;
    logic [31:0]        data_rdata_q, data_rdata_d;

    logic               accept;
    logic               grant_inst;
    logic               grant_data;
    logic               capture;

    // A new request may only be taken when nothing is in flight; never during reset.
    assign accept  = resetn && ((state_q == IDLE) || (state_q == RESP));
    assign capture = (state_q == WAIT) && (lat_q == '0);

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk          (clk),
        .resetn       (resetn),
        .accept_i     (accept),
        .inst_req_i   (bus.inst_req),
        .data_req_i   (bus.data_req),
        .grant_inst_o (grant_inst),
        .grant_data_o (grant_data)
    );

    // FSM state and latency counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state logic; WAIT is always visited so MEM_LAT=1 lands directly on the capture cycle.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        unique case (state_q)
            IDLE, RESP: begin
                state_d = (grant_inst || grant_data) ? ISSUE : IDLE;
            end
            ISSUE: begin
                lat_d   = LAT_W'(LAT_EFF - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the winning request; fetches are stored as reads with no strobes.
    always_comb begin
        req_d = req_q;
        if (grant_data) begin
            req_d.addr  = bus.data_addr;
            req_d.wdata = bus.data_wdata;
            req_d.wstrb = bus.data_wstrb;
            req_d.wr    = bus.data_wr;
            req_d.owner = OWN_DATA;
        end else if (grant_inst) begin
            req_d.addr  = bus.inst_addr;
            req_d.wdata = '0;
            req_d.wstrb = '0;
            req_d.wr    = 1'b0;
            req_d.owner = OWN_INST;
        end
    end

    // Request register; stale contents are harmless because every use is gated by state.
    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

    // Read data steering into the owner's holding register.
    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (capture && !req_q.wr) begin
            if (req_q.owner == OWN_INST) begin
                inst_rdata_d = bus.mem_rdata;
            end else begin
                data_rdata_d = bus.mem_rdata;
            end
        end
    end

    // Read data holding registers; cleared by reset so the outputs read back as zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Output decode from state; the memory port is quiet outside ISSUE.
    always_comb begin
        bus.inst_addr_ok = grant_inst;
        bus.data_addr_ok = grant_data;
        bus.inst_data_ok = (state_q == RESP) && (req_q.owner == OWN_INST);
        bus.data_data_ok = (state_q == RESP) && (req_q.owner == OWN_DATA);
        bus.inst_rdata   = inst_rdata_q;
        bus.data_rdata   = data_rdata_q;
        bus.mem_en       = 1'b0;
        bus.mem_wen      = 4'b0000;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        busy             = (state_q == ISSUE) || (state_q == WAIT);
        if (state_q == ISSUE) begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = req_q.addr;
            bus.mem_wdata = req_q.wdata;
            if ((req_q.owner == OWN_DATA) && req_q.wr) begin
                bus.mem_wen = req_q.wstrb;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=4.
module tb_mem_arbiter;

    logic clk;
    logic resetn;
    logic busy1;
    logic busy4;

    int checks;
    int errors;

    mem_arbiter_if if1 ();
    mem_arbiter_if if4 ();

    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if1),
        .busy   (busy1)
    );

    mem_arbiter #(.MEM_LAT(4), .STARVE_MAX(3)) dut4 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if4),
        .busy   (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet1(input string tag);
        check({tag, " busy"},     {31'd0, busy1},        32'd0);
        check({tag, " mem_en"},   {31'd0, if1.mem_en},   32'd0);
        check({tag, " mem_wen"},  {28'd0, if1.mem_wen},  32'd0);
        check({tag, " mem_addr"}, if1.mem_addr,          32'd0);
        check({tag, " i_aok"},    {31'd0, if1.inst_addr_ok}, 32'd0);
        check({tag, " d_aok"},    {31'd0, if1.data_addr_ok}, 32'd0);
        check({tag, " i_dok"},    {31'd0, if1.inst_data_ok}, 32'd0);
        check({tag, " d_dok"},    {31'd0, if1.data_data_ok}, 32'd0);
        check({tag, " i_rdata"},  if1.inst_rdata,        32'd0);
        check({tag, " d_rdata"},  if1.data_rdata,        32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b1;
        if1.inst_req = 0; if1.inst_addr = 0; if1.data_req = 0; if1.data_wr = 0;
        if1.data_wstrb = 0; if1.data_addr = 0; if1.data_wdata = 0; if1.mem_rdata = 0;
        if4.inst_req = 0; if4.inst_addr = 0; if4.data_req = 0; if4.data_wr = 0;
        if4.data_wstrb = 0; if4.data_addr = 0; if4.data_wdata = 0; if4.mem_rdata = 0;

        // Reset state
        #1 resetn = 1'b0;
        #1;
        check_quiet1("rst");
        check("rst4 busy", {31'd0, busy4}, 32'd0);
        check("rst4 i_rdata", if4.inst_rdata, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Single read, MEM_LAT=1
        if1.data_req = 1; if1.data_wr = 0; if1.data_addr = 32'h100;
        if1.mem_rdata = 32'hDEADBEEF;
        #1;
        check("rd T d_aok", {31'd0, if1.data_addr_ok}, 32'd1);
        check("rd T i_aok", {31'd0, if1.inst_addr_ok}, 32'd0);
        check("rd T busy",  {31'd0, busy1},            32'd0);
        tick();
        if1.data_req = 0;
        check("rd T+1 mem_en",   {31'd0, if1.mem_en},  32'd1);
        check("rd T+1 mem_addr", if1.mem_addr,         32'h100);
        check("rd T+1 mem_wen",  {28'd0, if1.mem_wen}, 32'd0);
        check("rd T+1 busy",     {31'd0, busy1},       32'd1);
        tick();
        check("rd T+2 mem_en", {31'd0, if1.mem_en},       32'd0);
        check("rd T+2 d_dok",  {31'd0, if1.data_data_ok}, 32'd0);
        tick();
        check("rd T+3 d_dok",   {31'd0, if1.data_data_ok}, 32'd1);
        check("rd T+3 i_dok",   {31'd0, if1.inst_data_ok}, 32'd0);
        check("rd T+3 d_rdata", if1.data_rdata,            32'hDEADBEEF);
        check("rd T+3 busy",    {31'd0, busy1},            32'd0);
        tick();
        check("rd T+4 d_dok", {31'd0, if1.data_data_ok}, 32'd0);

        // Byte write: mem_wen pulses once, data_rdata untouched
        if1.data_req = 1; if1.data_wr = 1; if1.data_wstrb = 4'b0010;
        if1.data_addr = 32'h204; if1.data_wdata = 32'h0000AB00;
        if1.mem_rdata = 32'h12345678;
        #1;
        check("wr T d_aok",   {31'd0, if1.data_addr_ok}, 32'd1);
        check("wr T mem_wen", {28'd0, if1.mem_wen},      32'd0);
        tick();
        if1.data_req = 0; if1.data_wr = 0; if1.data_wstrb = 0;
        check("wr T+1 mem_wen",   {28'd0, if1.mem_wen}, 32'h2);
        check("wr T+1 mem_addr",  if1.mem_addr,         32'h204);
        check("wr T+1 mem_wdata", if1.mem_wdata,        32'h0000AB00);
        tick();
        check("wr T+2 mem_wen", {28'd0, if1.mem_wen}, 32'd0);
        tick();
        check("wr T+3 d_dok",   {31'd0, if1.data_data_ok}, 32'd1);
        check("wr T+3 d_rdata", if1.data_rdata,            32'hDEADBEEF);
        tick();

        // Simultaneous requests: data first, fetch accepted in the data RESP cycle
        if1.inst_req = 1; if1.inst_addr = 32'h400;
        if1.data_req = 1; if1.data_wr = 0; if1.data_addr = 32'h500;
        if1.mem_rdata = 32'h11112222;
        #1;
        check("sim T d_aok", {31'd0, if1.data_addr_ok}, 32'd1);
        check("sim T i_aok", {31'd0, if1.inst_addr_ok}, 32'd0);
        tick();
        if1.data_req = 0;
        check("sim T+1 mem_addr", if1.mem_addr,            32'h500);
        check("sim T+1 i_aok",    {31'd0, if1.inst_addr_ok}, 32'd0);
        tick();
        tick();
        check("sim RESP d_dok", {31'd0, if1.data_data_ok}, 32'd1);
        check("sim RESP i_aok", {31'd0, if1.inst_addr_ok}, 32'd1);
        check("sim RESP d_aok", {31'd0, if1.data_addr_ok}, 32'd0);
        check("sim RESP d_rdata", if1.data_rdata,          32'h11112222);
        if1.mem_rdata = 32'h33334444;
        tick();
        if1.inst_req = 0;
        check("sim I mem_addr", if1.mem_addr,         32'h400);
        check("sim I mem_wen",  {28'd0, if1.mem_wen}, 32'd0);
        tick();
        tick();
        check("sim I i_dok",    {31'd0, if1.inst_data_ok}, 32'd1);
        check("sim I d_dok",    {31'd0, if1.data_data_ok}, 32'd0);
        check("sim I i_rdata",  if1.inst_rdata,            32'h33334444);
        check("sim I d_rdata",  if1.data_rdata,            32'h11112222);
        tick();

        // Starvation: both held, data writes with full strobes; expect D,D,D,I,D,D,D,I
        if1.inst_req = 1; if1.inst_addr = 32'h800;
        if1.data_req = 1; if1.data_wr = 1; if1.data_wstrb = 4'hF;
        if1.data_addr = 32'h900; if1.data_wdata = 32'hCAFEF00D;
        #1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("stv g%0d d_aok", k), {31'd0, if1.data_addr_ok}, (k % 4 == 3) ? 32'd0 : 32'd1);
            check($sformatf("stv g%0d i_aok", k), {31'd0, if1.inst_addr_ok}, (k % 4 == 3) ? 32'd1 : 32'd0);
            if (k == 7) begin
                if1.inst_req = 0; if1.data_req = 0; if1.data_wr = 0; if1.data_wstrb = 0;
            end
            tick();
            check($sformatf("stv g%0d mem_wen", k), {28'd0, if1.mem_wen}, (k % 4 == 3) ? 32'd0 : 32'hF);
            tick();
            tick();
            check($sformatf("stv g%0d dok excl", k),
                  {31'd0, if1.inst_data_ok & if1.data_data_ok}, 32'd0);
        end
        tick();

        // Latency: MEM_LAT=4 fetch
        if4.inst_req = 1; if4.inst_addr = 32'hBFC00000; if4.mem_rdata = 32'h3C080001;
        #1;
        check("lat T i_aok", {31'd0, if4.inst_addr_ok}, 32'd1);
        check("lat T busy",  {31'd0, busy4},            32'd0);
        tick();
        if4.inst_req = 0;
        check("lat T+1 mem_en",   {31'd0, if4.mem_en}, 32'd1);
        check("lat T+1 mem_addr", if4.mem_addr,        32'hBFC00000);
        check("lat T+1 busy",     {31'd0, busy4},      32'd1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check($sformatf("lat T+%0d busy", c),   {31'd0, busy4},            32'd1);
            check($sformatf("lat T+%0d mem_en", c), {31'd0, if4.mem_en},       32'd0);
            check($sformatf("lat T+%0d i_dok", c),  {31'd0, if4.inst_data_ok}, 32'd0);
        end
        tick();
        check("lat T+6 i_dok",   {31'd0, if4.inst_data_ok}, 32'd1);
        check("lat T+6 i_rdata", if4.inst_rdata,            32'h3C080001);
        check("lat T+6 busy",    {31'd0, busy4},            32'd0);
        tick();
        check("lat T+7 i_dok", {31'd0, if4.inst_data_ok}, 32'd0);

        // Reset during WAIT: outputs clear at once, no data_ok afterwards
        if1.data_req = 1; if1.data_wr = 0; if1.data_addr = 32'h600;
        if1.mem_rdata = 32'h55556666;
        #1;
        check("mrst T d_aok", {31'd0, if1.data_addr_ok}, 32'd1);
        tick();
        tick();
        check("mrst WAIT busy", {31'd0, busy1}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check_quiet1("mrst low");
        check("mrst low rdata4", if4.inst_rdata, 32'd0);
        tick();
        check("mrst low+1 d_dok", {31'd0, if1.data_data_ok}, 32'd0);
        check("mrst low+1 d_aok", {31'd0, if1.data_addr_ok}, 32'd0);
        tick();
        if1.data_req = 0;
        resetn = 1'b1;
        tick();
        check("mrst rel d_dok",   {31'd0, if1.data_data_ok}, 32'd0);
        check("mrst rel d_rdata", if1.data_rdata,            32'd0);
        tick();
        check("mrst rel2 d_dok", {31'd0, if1.data_data_ok}, 32'd0);

        // Fresh read after reset release
        if1.data_req = 1; if1.data_addr = 32'h700; if1.mem_rdata = 32'h77778888;
        #1;
        check("post d_aok", {31'd0, if1.data_addr_ok}, 32'd1);
        tick();
        if1.data_req = 0;
        check("post mem_en",   {31'd0, if1.mem_en}, 32'd1);
        check("post mem_addr", if1.mem_addr,        32'h700);
        tick();
        tick();
        check("post d_dok",   {31'd0, if1.data_data_ok}, 32'd1);
        check("post d_rdata", if1.data_rdata,            32'h77778888);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one SRAM-like memory port between the CPU core's instruction-fetch and data-access interfaces. It sits between `mips` and a single unified memory. It arbitrates requests, sequences one transaction at a time with a parameterised read latency, and returns per-requester `addr_ok`/`data_ok` handshakes. Data accesses have priority, and a starvation counter guarantees fetch progress.

## Interface
Parameters:
- `MEM_LAT`, 1: memory read latency in cycles from `mem_en` to valid `mem_rdata`; legal range 1..4.
- `STARVE_MAX`, 3: number of consecutive data grants while `inst_req` is pending before instruction is forced.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `inst_req` in 1: fetch request, held until `inst_addr_ok`.
- `inst_addr` in 32: fetch address.
- `inst_addr_ok` out 1: fetch request accepted this cycle.
- `inst_data_ok` out 1: one-cycle pulse; `inst_rdata` valid.
- `inst_rdata` out 32: fetched word, held until next fetch completes.
- `data_req` in 1: data request, held until `data_addr_ok`.
- `data_wr` in 1: 1 = write, 0 = read.
- `data_wstrb` in 4: byte write strobes.
- `data_addr` in 32: data address.
- `data_wdata` in 32: write data.
- `data_addr_ok` out 1: data request accepted this cycle.
- `data_data_ok` out 1: one-cycle pulse; read data valid or write done.
- `data_rdata` out 32: read word, held until next data read completes.
- `mem_en` out 1: memory access strobe.
- `mem_wen` out 4: byte write enables.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data.
- `busy` out 1: transaction in ISSUE or WAIT.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP. Only one transaction is ever outstanding.
- **Accept (IDLE or RESP):**
  - The grant is computed combinationally. `data_req` wins unless `inst_req` is high and `starve_cnt == STARVE_MAX`.
  - The winner's `*_addr_ok` is 1 in the same cycle.
  - Address, wr, wstrb, wdata and owner are registered at the cycle's end.
  - The next state is ISSUE.
  - With no request, the FSM goes to (or stays in) IDLE.
- **ISSUE:**
  - `mem_en` = 1, `mem_addr` and `mem_wdata` come from the registers.
  - `mem_wen` = wstrb for writes, 4'b0 for reads.
  - Fetches always drive `mem_wen` = 0.
  - Load the latency counter with `MEM_LAT`-1 and go to WAIT. When `MEM_LAT`=1, go straight to the capture cycle.
- **WAIT:**
  - The counter decrements each cycle; `mem_en` = 0.
  - When the counter reaches 0, `mem_rdata` is valid. For reads, capture it into the owner's `rdata` register. Writes capture nothing.
  - Then go to RESP.
- **RESP:** the owner's `*_data_ok` = 1 for exactly one cycle, and arbitration proceeds as in IDLE.
- **starve_cnt** (2 bits wider than needed, saturating at `STARVE_MAX`):
  - Increments on a data grant while `inst_req` = 1.
  - Clears on an instruction grant, or when `inst_req` = 0.
- Addresses pass through unmodified; alignment is the requester's responsibility.

## Timing
- Reset (asynchronous, `resetn` low): state = IDLE and `starve_cnt` = 0. Every output is 0, including `inst_rdata` and `data_rdata`.
- `*_addr_ok` is forced to 0 while `resetn` is low.
- Reset mid-transaction discards the pending access and emits no `data_ok`.
- A request accepted in cycle T completes as follows:
  - `mem_en` is high in T+1.
  - Data is captured at the end of T+1+`MEM_LAT`.
  - `*_data_ok` is high in T+2+`MEM_LAT`.
- Back-to-back throughput is one transaction per `MEM_LAT`+2 cycles, because RESP overlaps the next accept.
- Simultaneous `inst_req` and `data_req`: only one `addr_ok` per cycle, never both.
- A requester must hold its request stable until `addr_ok`. Deasserting early is legal and simply cancels, with no side effects.
- `inst_data_ok` and `data_data_ok` are never high together.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the owner enum (OWN_INST, OWN_DATA);
  - the `MEM_LAT` legal-range constants.
- Sub-module `mem_arb_grant`: combinational priority plus the registered starvation counter. It outputs `grant_inst` and `grant_data`.
- The top holds the FSM, latency counter, request registers and rdata registers.

## Test plan
- **Single read:** `MEM_LAT`=1, `data_req` read of 0x100 with memory returning 0xDEADBEEF.
  - `data_addr_ok` in T, `mem_en` in T+1, `data_data_ok` in T+3.
  - `data_rdata` = 0xDEADBEEF.
- **Byte write:** `data_wr`=1, wstrb 4'b0010, wdata 0x0000AB00 to 0x204.
  - `mem_wen` = 4'b0010 for exactly one cycle.
  - `data_data_ok` in T+3; `data_rdata` unchanged.
- **Simultaneous requests:** `inst_req` and `data_req` both high.
  - Data is granted first and the instruction is accepted in the data RESP cycle.
  - Instruction fetches never produce a nonzero `mem_wen`.
- **Starvation:** `data_req` and `inst_req` held high continuously, `STARVE_MAX`=3.
  - Grant order is D, D, D, I, D, D, D, I.
- **Latency:** `MEM_LAT`=4, fetch 0xBFC00000 returning 0x3C080001.
  - `inst_data_ok` at T+6 with `inst_rdata` = 0x3C080001.
  - `busy` high T+1..T+5.
- **Reset mid-transaction:** `resetn` pulled low during WAIT.
  - All outputs are 0 immediately and no `data_ok` follows.
  - After release, a new read completes normally.
